// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared FSM encoding, colours and coordinate width for the piece path
package vga_pkg;

    localparam int COORD_W = 10;

    typedef enum logic [1:0] {
        SPAWN = 2'd0,
        FALL  = 2'd1,
        LAND  = 2'd2
    } state_t;

    localparam logic [2:0] COLOR_DEFAULT = 3'b100;
    localparam logic [2:0] COLOR_BLACK   = 3'b000;

    // A black piece would be invisible on the black playfield.
    function automatic logic [2:0] spawn_color(input logic [2:0] req);
        return (req == COLOR_BLACK) ? COLOR_DEFAULT : req;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - 2-FF synchroniser plus stability counter with a rising press pulse
module button_debounce #(
    parameter int DEBOUNCE_TICKS = 250000
) (
    input  logic Clock,
    input  logic Reset,
    input  logic iRaw,
    output logic oLevel,
    output logic oPress
);

    localparam int CW = (DEBOUNCE_TICKS > 2) ? $clog2(DEBOUNCE_TICKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_TICKS - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] count;
    logic          level;
    logic          press;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            count <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            sync1 <= iRaw;
            sync2 <= sync1;
            press <= 1'b0;
            // Any return to the accepted level restarts the stability window.
            if (sync2 == level) begin
                count <= '0;
            end else if (count == LAST) begin
                count <= '0;
                level <= sync2;
                press <= sync2;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

    assign oLevel = level;
    assign oPress = press;

endmodule

// File: rtl/piece_motion_ctrl.sv
// rtl/piece_motion_ctrl.sv - button-driven and gravity-driven piece offsets for the VGA controller
module piece_motion_ctrl
    import vga_pkg::*;
#(
    parameter logic [COORD_W-1:0] STEP      = 10'd32,
    parameter logic [COORD_W-1:0] X_SPAWN   = 10'd96,
    parameter logic [COORD_W-1:0] X_MAX_OFF = 10'd192,
    parameter logic [COORD_W-1:0] Y_MAX_OFF = 10'd288,
    parameter int GRAVITY_TICKS  = 25000000,
    parameter int DEBOUNCE_TICKS = 250000
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               iLeft,
    input  logic               iRight,
    input  logic               iDown,
    input  logic [2:0]         iColor,
    output logic [COORD_W-1:0] oXOffset,
    output logic [COORD_W-1:0] oYOffset,
    output logic [2:0]         oColor,
    output logic               oLanded
);

    localparam int GW = (GRAVITY_TICKS > 2) ? $clog2(GRAVITY_TICKS) : 1;
    localparam logic [GW-1:0] GRAV_LAST = GW'(GRAVITY_TICKS - 1);

    logic left_press;
    logic right_press;
    logic down_press;
    logic left_level;
    logic right_level;
    logic down_level;
    logic unused_levels;

    button_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_left (
        .Clock  (Clock),
        .Reset  (Reset),
        .iRaw   (iLeft),
        .oLevel (left_level),
        .oPress (left_press)
    );

    button_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_right (
        .Clock  (Clock),
        .Reset  (Reset),
        .iRaw   (iRight),
        .oLevel (right_level),
        .oPress (right_press)
    );

    button_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_down (
        .Clock  (Clock),
        .Reset  (Reset),
        .iRaw   (iDown),
        .oLevel (down_level),
        .oPress (down_press)
    );

    assign unused_levels = left_level ^ right_level ^ down_level;

    state_t             state;
    state_t             state_n;
    logic [GW-1:0]      grav;
    logic [GW-1:0]      grav_n;
    logic               tick;
    logic [COORD_W-1:0] x_n;
    logic [COORD_W-1:0] y_n;
    logic [2:0]         color_n;
    logic               landed_n;
    logic [COORD_W:0]   y_sum;

    assign tick = (grav == GRAV_LAST);

    always_comb begin
        state_n  = state;
        x_n      = oXOffset;
        y_n      = oYOffset;
        color_n  = oColor;
        landed_n = 1'b0;
        grav_n   = tick ? '0 : grav + 1'b1;
        y_sum    = {1'b0, oYOffset} + {1'b0, STEP};
        case (state)
            SPAWN: begin
                x_n     = X_SPAWN;
                y_n     = '0;
                color_n = spawn_color(iColor);
                grav_n  = '0;
                state_n = FALL;
            end
            FALL: begin
                if (down_press) begin
                    grav_n = '0;
                end
                // Opposing presses in one cycle cancel out.
                if (left_press && !right_press && (oXOffset >= STEP)) begin
                    x_n = oXOffset - STEP;
                end else if (right_press && !left_press &&
                             (({1'b0, oXOffset} + {1'b0, STEP}) <= {1'b0, X_MAX_OFF})) begin
                    x_n = oXOffset + STEP;
                end
                if (tick || down_press) begin
                    if (y_sum >= {1'b0, Y_MAX_OFF}) begin
                        y_n      = Y_MAX_OFF;
                        landed_n = 1'b1;
                        state_n  = LAND;
                    end else begin
                        y_n = y_sum[COORD_W-1:0];
                    end
                end
            end
            LAND: begin
                state_n = SPAWN;
            end
            default: begin
                state_n = SPAWN;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= SPAWN;
            grav     <= '0;
            oXOffset <= X_SPAWN;
            oYOffset <= '0;
            oColor   <= COLOR_DEFAULT;
            oLanded  <= 1'b0;
        end else begin
            state    <= state_n;
            grav     <= grav_n;
            oXOffset <= x_n;
            oYOffset <= y_n;
            oColor   <= color_n;
            oLanded  <= landed_n;
        end
    end

endmodule
